// File: rtl/dram_master_pkg.sv
// Shared widths and FSM state type for the DRAM burst master.
package dram_master_pkg;
  localparam int BEAT_W   = 144;
  localparam int BEBEAT_W = 18;
  localparam int BURST_W  = 288;

  typedef enum logic [1:0] {
    IDLE,
    BEAT1,
    BEAT2
  } state_e;
endpackage

// File: rtl/dram_rd_assembler.sv
// Pairs two read-return beats into one burst response.
// Flags beats that arrive with no read outstanding.
module dram_rd_assembler
  import dram_master_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_valid,
  input  logic [BEAT_W-1:0]  rd_data,
  input  logic [7:0]         rd_outstanding,
  output logic               resp_valid,
  output logic [BURST_W-1:0] resp_data,
  output logic               err_orphan
);
  logic               phase_q, phase_d;
  logic [BEAT_W-1:0]  beat0_q, beat0_d;
  logic               resp_valid_q, resp_valid_d;
  logic [BURST_W-1:0] resp_data_q, resp_data_d;
  logic               err_q, err_d;

  always_comb begin
    phase_d      = phase_q;
    beat0_d      = beat0_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    err_d        = err_q;
    if (rd_valid) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        beat0_d = rd_data;
        if (rd_outstanding == 8'd0) err_d = 1'b1;
      end else begin
        resp_data_d  = {rd_data, beat0_q};
        resp_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q      <= 1'b0;
      beat0_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      beat0_q      <= beat0_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      err_q        <= err_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign err_orphan = err_q;
endmodule

// File: rtl/dram_burst_master.sv
// Two-beat DRAM command initiator with bounded read tracking.
// A burst leaves as a command+data beat, then a data-only beat.
module dram_burst_master
  import dram_master_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int MAX_RD = 32
) (
  input  logic                  dram_clk,
  input  logic                  dram_rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rnw,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [BURST_W-1:0]    req_wr_data,
  input  logic [2*BEBEAT_W-1:0] req_wr_be,
  output logic [31:0]           dram_cmd_addr,
  output logic                  dram_cmd_rnw,
  output logic                  dram_cmd_valid,
  output logic [BEAT_W-1:0]     dram_wr_data,
  output logic [BEBEAT_W-1:0]   dram_wr_be,
  input  logic                  dram_ready,
  input  logic [BEAT_W-1:0]     dram_rd_data,
  input  logic                  dram_rd_valid,
  output logic                  resp_valid,
  output logic [BURST_W-1:0]    resp_data,
  output logic [7:0]            rd_outstanding,
  output logic                  err_orphan
);
  state_e              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic                rnw_q, rnw_d;
  logic                valid_q, valid_d;
  logic [BEAT_W-1:0]   wdata_q, wdata_d;
  logic [BEBEAT_W-1:0] wbe_q, wbe_d;
  logic [BEAT_W-1:0]   hi_data_q, hi_data_d;
  logic [BEBEAT_W-1:0] hi_be_q, hi_be_d;
  logic [7:0]          out_q, out_d;
  logic                accept;
  logic                issue_rd;
  logic                retire_rd;

  assign req_ready = dram_rst_n && (state_q != BEAT1) &&
                     (!req_rnw || (out_q < 8'(MAX_RD)));
  assign accept    = req_valid && req_ready;
  assign issue_rd  = (state_q == BEAT1) && dram_ready && rnw_q;
  // Guard keeps an orphan-completed pair from wrapping the count
  assign retire_rd = resp_valid && (out_q != 8'd0);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rnw_d     = rnw_q;
    valid_d   = valid_q;
    wdata_d   = wdata_q;
    wbe_d     = wbe_q;
    hi_data_d = hi_data_q;
    hi_be_d   = hi_be_q;
    unique case (state_q)
      IDLE: ;
      BEAT1: begin
        if (dram_ready) begin
          state_d = BEAT2;
          valid_d = 1'b0;
          wdata_d = hi_data_q;
          wbe_d   = hi_be_q;
        end
      end
      BEAT2: begin
        state_d = IDLE;
        valid_d = 1'b0;
        wdata_d = '0;
        wbe_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d   = BEAT1;
      valid_d   = 1'b1;
      addr_d    = 32'({req_addr, 2'b00});
      rnw_d     = req_rnw;
      wdata_d   = req_rnw ? '0 : req_wr_data[BEAT_W-1:0];
      wbe_d     = req_rnw ? '0 : req_wr_be[BEBEAT_W-1:0];
      hi_data_d = req_rnw ? '0 : req_wr_data[BURST_W-1:BEAT_W];
      hi_be_d   = req_rnw ? '0 : req_wr_be[2*BEBEAT_W-1:BEBEAT_W];
    end
  end

  always_comb begin
    out_d = out_q;
    unique case ({issue_rd, retire_rd})
      2'b10:   out_d = out_q + 8'd1;
      2'b01:   out_d = out_q - 8'd1;
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge dram_clk) begin
    if (!dram_rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rnw_q     <= 1'b0;
      valid_q   <= 1'b0;
      wdata_q   <= '0;
      wbe_q     <= '0;
      hi_data_q <= '0;
      hi_be_q   <= '0;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rnw_q     <= rnw_d;
      valid_q   <= valid_d;
      wdata_q   <= wdata_d;
      wbe_q     <= wbe_d;
      hi_data_q <= hi_data_d;
      hi_be_q   <= hi_be_d;
      out_q     <= out_d;
    end
  end

  assign dram_cmd_addr  = addr_q;
  assign dram_cmd_rnw   = rnw_q;
  assign dram_cmd_valid = valid_q;
  assign dram_wr_data   = wdata_q;
  assign dram_wr_be     = wbe_q;
  assign rd_outstanding = out_q;

  dram_rd_assembler u_asm (
    .clk            (dram_clk),
    .rst_n          (dram_rst_n),
    .rd_valid       (dram_rd_valid),
    .rd_data        (dram_rd_data),
    .rd_outstanding (out_q),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .err_orphan     (err_orphan)
  );
endmodule

// File: tb/tb_dram_burst_master.sv
// Directed bench for dram_burst_master with a small DRAM model.
// Model drives controller inputs on the falling edge.
module tb_dram_burst_master;
  import dram_master_pkg::*;

  localparam int ADDR_W = 14;
  localparam int MAX_RD = 4;
  localparam int LAT    = 16;

  logic              dram_clk = 1'b0;
  logic              dram_rst_n = 1'b0;
  logic              req_valid, req_ready, req_rnw;
  logic [ADDR_W-1:0] req_addr;
  logic [287:0]      req_wr_data;
  logic [35:0]       req_wr_be;
  logic [31:0]       dram_cmd_addr;
  logic              dram_cmd_rnw, dram_cmd_valid;
  logic [143:0]      dram_wr_data;
  logic [17:0]       dram_wr_be;
  logic              dram_ready = 1'b0;
  logic [143:0]      dram_rd_data = '0;
  logic              dram_rd_valid = 1'b0;
  logic              resp_valid;
  logic [287:0]      resp_data;
  logic [7:0]        rd_outstanding;
  logic              err_orphan;

  always #5 dram_clk = ~dram_clk;

  dram_burst_master #(.ADDR_W(ADDR_W), .MAX_RD(MAX_RD)) dut (
    .dram_clk       (dram_clk),
    .dram_rst_n     (dram_rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_rnw        (req_rnw),
    .req_addr       (req_addr),
    .req_wr_data    (req_wr_data),
    .req_wr_be      (req_wr_be),
    .dram_cmd_addr  (dram_cmd_addr),
    .dram_cmd_rnw   (dram_cmd_rnw),
    .dram_cmd_valid (dram_cmd_valid),
    .dram_wr_data   (dram_wr_data),
    .dram_wr_be     (dram_wr_be),
    .dram_ready     (dram_ready),
    .dram_rd_data   (dram_rd_data),
    .dram_rd_valid  (dram_rd_valid),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .rd_outstanding (rd_outstanding),
    .err_orphan     (err_orphan)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [287:0] got,
                     input logic [287:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [287:0] pat(input int i);
    logic [31:0] w;
    w = 32'(i) * 32'h0101_0101 + 32'h1234_0007;
    return {9{w}};
  endfunction

  // Controls written only by the stimulus process
  logic stall_rd = 1'b0;
  logic hold_ready = 1'b0;
  int   drop_at = -1;
  int   inj_req = 0;

  // Model state, written only by the model process
  logic [287:0] mem [0:127] = '{default: '0};
  logic [287:0] resp_q [$];
  int   rq_addr [$];
  int   rq_due [$];
  int   cyc = 0, cmd_cnt = 0, blk = 0, inj_done = 0;
  int   last_cmd = -100, gap2_cnt = 0, lowvalid_cnt = 0, hold_err = 0;
  int   resp_cnt = 0, max_out = 0, pend_addr = 0, cur_rd = 0;
  bit   dropped = 0, pend2 = 0, pend_rnw = 0, rph = 0, prev_low = 0;
  logic [194:0] prev_out = '0;

  task automatic merge(input int a, input int half, input logic [143:0] d,
                       input logic [17:0] be);
    for (int i = 0; i < 18; i++)
      if (be[i]) mem[a][half*144 + i*8 +: 8] = d[i*8 +: 8];
  endtask

  always @(negedge dram_clk) begin
    logic [194:0] cur;
    cyc++;
    if (pend2) begin
      if (!pend_rnw) merge(pend_addr, 1, dram_wr_data, dram_wr_be);
      pend2 = 0;
    end
    if (drop_at >= 0 && cmd_cnt == drop_at && !dropped) begin
      blk = 4;
      dropped = 1;
    end
    dram_ready = !hold_ready && (blk == 0);
    if (blk > 0) blk--;
    cur = {dram_cmd_addr, dram_cmd_rnw, dram_wr_data, dram_wr_be};
    if (dram_cmd_valid && prev_low && cur != prev_out) hold_err++;
    prev_low = dram_cmd_valid && !dram_ready;
    prev_out = cur;
    if (dram_cmd_valid && !dram_ready) lowvalid_cnt++;
    if (dram_cmd_valid && dram_ready) begin
      cmd_cnt++;
      if (cyc - last_cmd == 2) gap2_cnt++;
      last_cmd  = cyc;
      pend2     = 1;
      pend_addr = int'(dram_cmd_addr >> 2);
      pend_rnw  = dram_cmd_rnw;
      if (!dram_cmd_rnw) merge(pend_addr, 0, dram_wr_data, dram_wr_be);
      else begin
        rq_addr.push_back(pend_addr);
        rq_due.push_back(cyc + LAT);
      end
    end
    dram_rd_valid = 1'b0;
    if (inj_done != inj_req) begin
      inj_done      = inj_req;
      dram_rd_valid = 1'b1;
      dram_rd_data  = '1;
    end else if (rph) begin
      dram_rd_valid = 1'b1;
      dram_rd_data  = mem[cur_rd][287:144];
      rph = 0;
    end else if (!stall_rd && rq_due.size() > 0 && rq_due[0] <= cyc) begin
      cur_rd = rq_addr.pop_front();
      rq_due.delete(0);
      dram_rd_valid = 1'b1;
      dram_rd_data  = mem[cur_rd][143:0];
      rph = 1;
    end
    if (resp_valid) begin
      resp_q.push_back(resp_data);
      resp_cnt++;
    end
    if (int'(rd_outstanding) > max_out) max_out = int'(rd_outstanding);
  end

  task automatic send(input logic rnw, input int a, input logic [287:0] d,
                      input logic [35:0] be);
    int k = 0;
    req_rnw     = rnw;
    req_addr    = ADDR_W'(a);
    req_wr_data = d;
    req_wr_be   = be;
    req_valid   = 1'b1;
    while (!req_ready && k < 200) begin
      @(negedge dram_clk);
      k++;
    end
    chk("send_accept", req_ready, 1);
    @(posedge dram_clk);
    @(negedge dram_clk);
  endtask

  task automatic wait_resp(input string tag, input int target, input int budget);
    int k = 0;
    while (resp_cnt < target && k < budget) begin
      @(negedge dram_clk);
      k++;
    end
    chk(tag, resp_cnt >= target, 1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [143:0] aa, bb;
    logic [287:0] exp;
    int r0, q0, g0, l0, h0, c0, k, bad;
    aa = {36{4'hA}};
    bb = {36{4'hB}};
    req_valid = 0; req_rnw = 0; req_addr = '0;
    req_wr_data = '0; req_wr_be = '0;

    repeat (3) @(negedge dram_clk);
    req_valid = 1;
    chk("rst_ctl", {req_ready, dram_cmd_valid, dram_cmd_rnw, dram_cmd_addr,
                    dram_wr_be, resp_valid, rd_outstanding, err_orphan}, 0);
    chk("rst_data", {dram_wr_data, resp_data[143:0]}, 0);
    req_valid = 0;
    dram_rst_n = 1;
    @(negedge dram_clk);

    // single write, addr 5
    req_rnw = 0; req_addr = 5; req_wr_data = {bb, aa};
    req_wr_be = '1; req_valid = 1;
    chk("t1_ready", req_ready, 1);
    @(posedge dram_clk); #1;
    chk("t1_b0", {dram_cmd_valid, dram_cmd_rnw, dram_cmd_addr}, {2'b10, 32'h14});
    chk("t1_b0_data", {dram_wr_be, dram_wr_data}, {18'h3ffff, aa});
    req_valid = 0;
    @(posedge dram_clk); #1;
    chk("t1_b1", {dram_cmd_valid, dram_cmd_addr}, {1'b0, 32'h14});
    chk("t1_b1_data", {dram_wr_be, dram_wr_data}, {18'h3ffff, bb});
    repeat (3) @(negedge dram_clk);
    chk("t1_mem", mem[5], {bb, aa});

    // read back addr 5
    r0 = resp_cnt;
    send(1, 5, '0, '0);
    req_valid = 0;
    chk("t2_rd_cmd", {dram_cmd_valid, dram_cmd_rnw, dram_wr_be, dram_wr_data},
        {2'b11, 162'b0});
    @(negedge dram_clk);
    chk("t2_out1", rd_outstanding, 1);
    wait_resp("t2_resp_seen", r0 + 1, 100);
    chk("t2_resp", resp_q[resp_q.size()-1], {bb, aa});
    repeat (2) @(negedge dram_clk);
    chk("t2_out0", rd_outstanding, 0);

    // 100 back-to-back writes with a ready drop after 64
    g0 = gap2_cnt; l0 = lowvalid_cnt; h0 = hold_err; c0 = cmd_cnt;
    drop_at = cmd_cnt + 64;
    for (int i = 0; i < 100; i++) send(0, i, pat(i), '1);
    req_valid = 0;
    repeat (4) @(negedge dram_clk);
    chk("t3_cmds", cmd_cnt - c0, 100);
    chk("t3_alt_cycles", gap2_cnt - g0, 98);
    chk("t3_low_cycles", lowvalid_cnt - l0, 3);
    chk("t3_hold", hold_err - h0, 0);
    bad = 0;
    for (int i = 0; i < 100; i++) if (mem[i] !== pat(i)) bad++;
    chk("t3_mem", bad, 0);

    // outstanding limit with read returns stalled
    stall_rd = 1;
    r0 = resp_cnt;
    q0 = resp_q.size();
    for (int i = 0; i < 4; i++) send(1, 10 + i, '0, '0);
    req_rnw = 1; req_addr = 14; req_valid = 1;
    @(negedge dram_clk);
    chk("t4_out4", rd_outstanding, 4);
    chk("t4_ready_low", req_ready, 0);
    repeat (10) @(negedge dram_clk);
    chk("t4_still_low", {req_ready, rd_outstanding}, {1'b0, 8'd4});
    chk("t4_no_resp", resp_cnt - r0, 0);
    stall_rd = 0;
    k = 0;
    while (!req_ready && k < 200) begin
      @(negedge dram_clk);
      k++;
    end
    chk("t4_reopen", req_ready, 1);
    chk("t4_first_resp", resp_cnt - r0, 1);
    send(1, 14, '0, '0);
    send(1, 15, '0, '0);
    req_valid = 0;
    wait_resp("t4_all_resp", r0 + 6, 300);
    for (int i = 0; i < 6; i++) chk("t4_order", resp_q[q0 + i], pat(10 + i));
    repeat (3) @(negedge dram_clk);
    chk("t4_out0", rd_outstanding, 0);
    chk("t4_max", max_out, 4);

    // partial byte enables
    send(0, 20, '1, 36'h0_0000_0001);
    req_valid = 0;
    repeat (4) @(negedge dram_clk);
    exp = pat(20);
    exp[7:0] = 8'hFF;
    chk("t5_partial", mem[20], exp);
    chk("t5_neighbor", mem[21], pat(21));

    // orphan beat, then reset in BEAT1
    chk("t6_pre", {err_orphan, rd_outstanding}, 0);
    inj_req = inj_req + 1;
    repeat (3) @(negedge dram_clk);
    chk("t6_orphan", err_orphan, 1);
    repeat (5) @(negedge dram_clk);
    chk("t6_held", err_orphan, 1);
    hold_ready = 1;
    send(0, 30, pat(1), '1);
    chk("t6_in_beat1", {dram_cmd_valid, dram_cmd_addr}, {1'b1, 32'd120});
    dram_rst_n = 0;
    @(posedge dram_clk); #1;
    chk("t6_rst_ctl", {req_ready, dram_cmd_valid, dram_cmd_rnw, dram_cmd_addr,
                       dram_wr_be, resp_valid, rd_outstanding, err_orphan}, 0);
    chk("t6_rst_data", dram_wr_data, 0);
    chk("t6_rst_resp", resp_data, 0);
    @(negedge dram_clk);
    req_valid = 0;
    hold_ready = 0;
    dram_rst_n = 1;
    @(negedge dram_clk);

    // phase was cleared: next read pairs correctly
    r0 = resp_cnt;
    send(1, 5, '0, '0);
    req_valid = 0;
    wait_resp("t7_resp_seen", r0 + 1, 100);
    chk("t7_resp", resp_q[resp_q.size()-1], pat(5));
    chk("t7_no_orphan", err_orphan, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
